// File: rtl/md_pkg.sv
// md_pkg: shared MDOp encodings, MD unit latencies and issue-controller state.
package md_pkg;

    localparam logic [2:0] MD_MULTU = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_DIVU  = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_MADD  = 3'b100;
    localparam logic [2:0] MD_MSUB  = 3'b101;
    localparam logic [2:0] MD_MADDU = 3'b110;
    localparam logic [2:0] MD_MSUBU = 3'b111;

    localparam logic [3:0] MD_MUL_LAT = 4'd4;
    localparam logic [3:0] MD_DIV_LAT = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUED = 2'd1,
        BUSY   = 2'd2
    } md_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: start/busy bus between the issue controller and the MD unit.
interface md_issue_ctrl_if;

    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [31:0] md_wd;
    logic        md_mthi;
    logic        md_mtlo;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    modport master (
        output md_start, md_op, md_a, md_b,
        output md_wd, md_mthi, md_mtlo,
        input  md_busy, md_hi, md_lo
    );

    modport slave (
        input  md_start, md_op, md_a, md_b,
        input  md_wd, md_mthi, md_mtlo,
        output md_busy, md_hi, md_lo
    );

endinterface

// File: rtl/md_busy_checker.sv
// md_busy_checker: countdown of expected MD busy cycles, sticky protocol_err.
// Only built when MD_ISSUE_CHECK_EN is defined.
`ifdef MD_ISSUE_CHECK_EN
module md_busy_checker
    import md_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_is_div,
    input  logic i_active,
    input  logic i_in_busy,
    input  logic i_busy,
    output logic o_err
);

    logic [3:0] r_cnt;
    logic       r_err;
    logic       w_early;
    logic       w_late;

    assign w_early = i_active & ~i_busy & (r_cnt != 4'd0);
    assign w_late  = i_in_busy & i_busy & (r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
            r_err <= 1'b0;
        end else begin
            if (i_start)
                r_cnt <= i_is_div ? MD_DIV_LAT : MD_MUL_LAT;
            else if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_early | w_late)
                r_err <= 1'b1;
        end
    end

    assign o_err = r_err;

endmodule
`endif

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage issue/stall controller for the HI/LO mul/div unit.
// Define MD_ISSUE_CHECK_EN to build the busy-protocol checker.
module md_issue_ctrl
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            e_valid,
    input  logic            e_md_op,
    input  logic [2:0]      e_mdop,
    input  logic            e_mthi,
    input  logic            e_mtlo,
    input  logic            e_mfhi,
    input  logic            e_mflo,
    input  logic [31:0]     e_rs,
    input  logic [31:0]     e_rt,
    md_issue_ctrl_if.master md,
    output logic            stall,
    output logic [31:0]     rd_data,
    output logic            rd_valid,
    output logic            protocol_err
);

    md_state_e r_state;

    logic w_idle;
    logic w_hilo_use;
    logic w_ok;
    logic w_issue;
    logic w_mthi;
    logic w_mtlo;
    logic w_mfhi;
    logic w_mflo;

    assign w_idle     = (r_state == IDLE);
    assign w_hilo_use = e_valid & (e_md_op | e_mthi | e_mtlo
                                   | e_mfhi | e_mflo);
    // Everything is forced quiet while reset is held.
    assign stall = ~reset & w_hilo_use & ~w_idle;
    assign w_ok  = ~reset & e_valid & w_idle;

    always_comb begin
        w_issue = 1'b0;
        w_mthi  = 1'b0;
        w_mtlo  = 1'b0;
        w_mfhi  = 1'b0;
        w_mflo  = 1'b0;
        if (w_ok) begin
            if (e_md_op)     w_issue = 1'b1;
            else if (e_mthi) w_mthi  = 1'b1;
            else if (e_mtlo) w_mtlo  = 1'b1;
            else if (e_mfhi) w_mfhi  = 1'b1;
            else if (e_mflo) w_mflo  = 1'b1;
        end
    end

    assign md.md_start = w_issue;
    assign md.md_op    = w_issue ? e_mdop : 3'd0;
    assign md.md_a     = w_issue ? e_rs : 32'd0;
    assign md.md_b     = w_issue ? e_rt : 32'd0;
    assign md.md_mthi  = w_mthi;
    assign md.md_mtlo  = w_mtlo;
    assign md.md_wd    = (w_mthi | w_mtlo) ? e_rs : 32'd0;

    assign rd_valid = w_mfhi | w_mflo;
    assign rd_data  = w_mfhi ? md.md_hi :
                      w_mflo ? md.md_lo : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (w_issue) r_state <= ISSUED;
                ISSUED:  r_state <= BUSY;
                BUSY:    if (!md.md_busy) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MD_ISSUE_CHECK_EN
    md_busy_checker u_chk (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_issue),
        .i_is_div  (is_div(e_mdop)),
        .i_active  (~w_idle),
        .i_in_busy (r_state == BUSY),
        .i_busy    (md.md_busy),
        .o_err     (protocol_err)
    );
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed vector table plus multi-cycle sequences.
// Includes a small behavioural MD unit on the slave side of the bus.
module tb_md_issue_ctrl;

`ifdef MD_ISSUE_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid, e_md_op, e_mthi, e_mtlo, e_mfhi, e_mflo;
    logic [2:0]  e_mdop;
    logic [31:0] e_rs, e_rt;
    logic        stall, rd_valid, protocol_err;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    md_issue_ctrl_if bus ();

    md_issue_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .e_valid      (e_valid),
        .e_md_op      (e_md_op),
        .e_mdop       (e_mdop),
        .e_mthi       (e_mthi),
        .e_mtlo       (e_mtlo),
        .e_mfhi       (e_mfhi),
        .e_mflo       (e_mflo),
        .e_rs         (e_rs),
        .e_rt         (e_rt),
        .md           (bus),
        .stall        (stall),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    // Behavioural MD unit: busy for 4 (mul) / 9 (div) cycles after start.
    int          busy_left;
    logic        kill;
    logic [31:0] m_hi, m_lo;
    logic        ovr_en;
    logic [31:0] ovr_hi, ovr_lo;

    assign bus.md_busy = (busy_left != 0);
    assign bus.md_hi   = ovr_en ? ovr_hi : m_hi;
    assign bus.md_lo   = ovr_en ? ovr_lo : m_lo;

    function automatic logic [63:0] md_calc(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [63:0] acc);
        logic [63:0] pu, ps;
        logic signed [31:0] sa, sb;
        pu = {32'd0, a} * {32'd0, b};
        ps = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        sa = a;
        sb = b;
        case (op)
            3'b000: return pu;
            3'b001: return ps;
            3'b010: return (b == 0) ? acc : {a % b, a / b};
            3'b011: return (b == 0) ? acc : {32'(sa % sb), 32'(sa / sb)};
            3'b100: return acc + ps;
            3'b101: return acc - ps;
            3'b110: return acc + pu;
            default: return acc - pu;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            busy_left <= 0;
            m_hi      <= 32'd0;
            m_lo      <= 32'd0;
        end else begin
            if (busy_left != 0)
                busy_left <= kill ? 0 : busy_left - 1;
            if (bus.md_start) begin
                busy_left <= (bus.md_op[2:1] == 2'b01) ? 9 : 4;
                {m_hi, m_lo} <= md_calc(bus.md_op, bus.md_a,
                                        bus.md_b, {m_hi, m_lo});
            end
            if (bus.md_mthi) m_hi <= bus.md_wd;
            if (bus.md_mtlo) m_lo <= bus.md_wd;
        end
    end

    typedef struct {
        logic        v, mdo;
        logic [2:0]  mdop;
        logic        thi, tlo, fhi, flo;
        logic [31:0] rs, rt, hi, lo;
        logic        x_start;
        logic [2:0]  x_op;
        logic [31:0] x_a, x_b, x_wd;
        logic        x_wthi, x_wtlo, x_rv;
        logic [31:0] x_rd;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic mdo,
                         input logic [2:0] op, input logic thi,
                         input logic tlo, input logic fhi,
                         input logic flo, input logic [31:0] rs,
                         input logic [31:0] rt);
        e_valid = v;
        e_md_op = mdo;
        e_mdop  = op;
        e_mthi  = thi;
        e_mtlo  = tlo;
        e_mfhi  = fhi;
        e_mflo  = flo;
        e_rs    = rs;
        e_rt    = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        drive(0, 0, 3'd0, 0, 0, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic drain(input int n);
        clear_in();
        repeat (n) tick();
    endtask

    // Issue an MD op, follow it with a dependent mfhi/mflo, check stalls.
    task automatic run_dep(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int nst, input logic hi,
                           input logic [31:0] exp);
        drive(1, 1, op, 0, 0, 0, 0, a, b);
        @(negedge clk);
        chk({tag, "_start"}, 32'(bus.md_start), 32'd1);
        chk({tag, "_op"}, 32'(bus.md_op), 32'(op));
        chk({tag, "_a"}, bus.md_a, a);
        chk({tag, "_b"}, bus.md_b, b);
        chk({tag, "_stall0"}, 32'(stall), 32'd0);
        tick();
        drive(1, 0, 3'd0, 0, 0, hi, !hi, 32'd0, 32'd0);
        for (int c = 1; c <= nst; c++) begin
            @(negedge clk);
            chk($sformatf("%s_stall%0d", tag, c), 32'(stall), 32'd1);
            chk($sformatf("%s_rv%0d", tag, c), 32'(rd_valid), 32'd0);
            chk($sformatf("%s_nost%0d", tag, c),
                32'(bus.md_start), 32'd0);
            tick();
        end
        @(negedge clk);
        chk({tag, "_stall_end"}, 32'(stall), 32'd0);
        chk({tag, "_rv_end"}, 32'(rd_valid), 32'd1);
        chk({tag, "_rd"}, rd_data, exp);
        chk({tag, "_perr"}, 32'(protocol_err), 32'd0);
        tick();
        clear_in();
    endtask

    initial begin
        vecs[0]  = '{0,0,3'd0,0,0,1,0, 32'd0,32'd0,32'h11,32'h22,
                     0,3'd0,32'd0,32'd0,32'd0,0,0,0,32'd0};
        vecs[1]  = '{1,0,3'd0,0,0,1,0, 32'd0,32'd0,32'hAAAA5555,32'h22,
                     0,3'd0,32'd0,32'd0,32'd0,0,0,1,32'hAAAA5555};
        vecs[2]  = '{1,0,3'd0,0,0,0,1, 32'd0,32'd0,32'h11,32'h12345678,
                     0,3'd0,32'd0,32'd0,32'd0,0,0,1,32'h12345678};
        vecs[3]  = '{1,0,3'd0,1,0,0,0, 32'hDEADBEEF,32'd5,32'h11,32'h22,
                     0,3'd0,32'd0,32'd0,32'hDEADBEEF,1,0,0,32'd0};
        vecs[4]  = '{1,0,3'd0,0,1,0,0, 32'hCAFEF00D,32'd5,32'h11,32'h22,
                     0,3'd0,32'd0,32'd0,32'hCAFEF00D,0,1,0,32'd0};
        vecs[5]  = '{1,0,3'd0,1,1,0,0, 32'h00000077,32'd0,32'h11,32'h22,
                     0,3'd0,32'd0,32'd0,32'h00000077,1,0,0,32'd0};
        vecs[6]  = '{1,0,3'd0,0,0,1,1, 32'd0,32'd0,32'h0000BEEF,32'h22,
                     0,3'd0,32'd0,32'd0,32'd0,0,0,1,32'h0000BEEF};
        vecs[7]  = '{1,0,3'd0,0,1,1,0, 32'h00000042,32'd0,32'h11,32'h22,
                     0,3'd0,32'd0,32'd0,32'h00000042,0,1,0,32'd0};
        vecs[8]  = '{1,1,3'b011,1,0,0,0, 32'd100,32'd0,32'h11,32'h22,
                     1,3'b011,32'd100,32'd0,32'd0,0,0,0,32'd0};
        vecs[9]  = '{1,1,3'b111,0,0,0,0, 32'h80000001,32'h7,32'h11,32'h22,
                     1,3'b111,32'h80000001,32'h7,32'd0,0,0,0,32'd0};
        vecs[10] = '{0,1,3'b001,0,0,0,0, 32'd9,32'd9,32'h11,32'h22,
                     0,3'd0,32'd0,32'd0,32'd0,0,0,0,32'd0};

        kill   = 1'b0;
        ovr_en = 1'b0;
        ovr_hi = 32'd0;
        ovr_lo = 32'd0;
        reset  = 1'b1;
        clear_in();
        tick();
        drive(1, 1, 3'b001, 1, 0, 0, 0, 32'd3, 32'd4);
        @(negedge clk);
        chk("rst_start", 32'(bus.md_start), 32'd0);
        chk("rst_mthi", 32'(bus.md_mthi), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_perr", 32'(protocol_err), 32'd0);
        tick();
        reset = 1'b0;
        clear_in();
        tick();

        ovr_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v, vecs[i].mdo, vecs[i].mdop, vecs[i].thi,
                  vecs[i].tlo, vecs[i].fhi, vecs[i].flo,
                  vecs[i].rs, vecs[i].rt);
            ovr_hi = vecs[i].hi;
            ovr_lo = vecs[i].lo;
            @(negedge clk);
            chk($sformatf("v%0d_start", i), 32'(bus.md_start),
                32'(vecs[i].x_start));
            chk($sformatf("v%0d_op", i), 32'(bus.md_op),
                32'(vecs[i].x_op));
            chk($sformatf("v%0d_a", i), bus.md_a, vecs[i].x_a);
            chk($sformatf("v%0d_b", i), bus.md_b, vecs[i].x_b);
            chk($sformatf("v%0d_wd", i), bus.md_wd, vecs[i].x_wd);
            chk($sformatf("v%0d_mthi", i), 32'(bus.md_mthi),
                32'(vecs[i].x_wthi));
            chk($sformatf("v%0d_mtlo", i), 32'(bus.md_mtlo),
                32'(vecs[i].x_wtlo));
            chk($sformatf("v%0d_rv", i), 32'(rd_valid),
                32'(vecs[i].x_rv));
            chk($sformatf("v%0d_rd", i), rd_data, vecs[i].x_rd);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
            tick();
            if (vecs[i].x_start) drain(12);
        end
        ovr_en = 1'b0;
        clear_in();
        tick();

        run_dep("mult", 3'b001, 32'hFFFFFFFD, 32'd2, 5, 1'b0,
                32'hFFFFFFFA);

        run_dep("divu", 3'b010, 32'd7, 32'd2, 10, 1'b1, 32'd1);
        drive(1, 0, 3'd0, 0, 0, 0, 1, 32'd0, 32'd0);
        @(negedge clk);
        chk("divu_lo_rv", 32'(rd_valid), 32'd1);
        chk("divu_lo", rd_data, 32'd3);
        tick();

        drive(1, 0, 3'd0, 1, 0, 0, 0, 32'h1234, 32'd0);
        @(negedge clk);
        chk("mthi_strobe", 32'(bus.md_mthi), 32'd1);
        chk("mthi_wd", bus.md_wd, 32'h1234);
        chk("mthi_stall", 32'(stall), 32'd0);
        tick();
        drive(1, 0, 3'd0, 0, 0, 1, 0, 32'd0, 32'd0);
        @(negedge clk);
        chk("mthi_strobe_off", 32'(bus.md_mthi), 32'd0);
        chk("mthi_readback", rd_data, 32'h1234);
        tick();

        drive(1, 1, 3'b011, 0, 0, 0, 0, 32'd20, 32'd3);
        tick();
        clear_in();
        tick();
        tick();
        reset = 1'b1;
        drive(1, 0, 3'd0, 0, 0, 0, 1, 32'd0, 32'd0);
        @(negedge clk);
        chk("rstdiv_stall_c3", 32'(stall), 32'd0);
        tick();
        reset = 1'b0;
        run_dep("rstmul", 3'b001, 32'd5, 32'd6, 5, 1'b0, 32'd30);

        drive(1, 1, 3'b000, 0, 0, 0, 0, 32'd3, 32'd4);
        tick();
        drive(1, 0, 3'd0, 0, 0, 0, 0, 32'd9, 32'd9);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk($sformatf("nohilo_stall%0d", c), 32'(stall), 32'd0);
            tick();
        end
        drive(1, 0, 3'd0, 0, 0, 0, 1, 32'd0, 32'd0);
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("nohilo_dep%0d", c), 32'(stall), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("nohilo_stall6", 32'(stall), 32'd0);
        chk("nohilo_rd", rd_data, 32'd12);
        tick();
        clear_in();

        drive(1, 1, 3'b001, 0, 0, 0, 0, 32'd2, 32'd2);
        tick();
        clear_in();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        tick();
        @(negedge clk);
        chk("perr_set", 32'(protocol_err), 32'(CHK_EN));
        repeat (5) tick();
        @(negedge clk);
        chk("perr_hold", 32'(protocol_err), 32'(CHK_EN));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("perr_clear", 32'(protocol_err), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
